// File: rtl/spi_follower_regs.sv
// SPI follower: {rw, addr[6:0]} command byte, then auto-incrementing data bytes, mapped onto
// single-cycle register-bank accesses. SPI pins are oversampled on clk through 2-flop synchronisers.
module spi_follower_regs #(
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              in,
  output logic              out,
  output logic              out_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_CMD  = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  // Register-bank port: wr_en is a lone strobe qualifying wr_addr/wr_data for one clk, with no
  // back-pressure; rd_data must follow rd_addr combinationally and is captured one clk later.

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q;
  logic in_s1_q, in_s2_q;

  logic [1:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic              out_q, out_d;
  logic              fresh_q, fresh_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_load_q, rd_load_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              sclk_edge, lead_ev, trail_ev, sample_ev, shift_ev;
  logic [7:0]        rx_next;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] addr_inc;

  assign sclk_edge = sclk_s2_q ^ sclk_s3_q;
  assign lead_ev   = sclk_edge && (sclk_s3_q == CPOL);
  assign trail_ev  = sclk_edge && (sclk_s2_q == CPOL);
  assign sample_ev = CPHA ? trail_ev : lead_ev;
  assign shift_ev  = CPHA ? lead_ev : trail_ev;

  assign rx_next  = {rx_q, in_s2_q};
  assign cmd_addr = ADDR_W'(rx_next[6:0]);
  assign addr_inc = addr_q + ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    out_d     = out_q;
    fresh_d   = fresh_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    rd_load_d = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    // A fresh read byte must reach MISO unshifted on the next shift edge.
    if (rd_load_q) begin
      tx_d    = rd_data;
      fresh_d = 1'b1;
    end

    case (state_q)
      ST_ARM: begin
        if (cs_s2_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!cs_s2_q) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
          tx_d      = 8'h00;
          out_d     = 1'b0;
          fresh_d   = 1'b0;
        end
      end
      default: begin
        if (shift_ev) begin
          if (fresh_q) begin
            out_d   = tx_q[7];
            fresh_d = 1'b0;
          end else begin
            tx_d  = {tx_q[6:0], 1'b0};
            out_d = tx_q[6];
          end
        end

        if (sample_ev) begin
          rx_d      = rx_next[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ST_CMD) begin
              state_d = ST_DATA;
              rw_d    = rx_next[7];
              addr_d  = cmd_addr;
              if (rx_next[7]) begin
                rd_addr_d = cmd_addr;
                rd_load_d = 1'b1;
              end
            end else begin
              addr_d = addr_inc;
              if (rw_q) begin
                rd_addr_d = addr_inc;
                rd_load_d = 1'b1;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = rx_next;
              end
            end
          end
        end

        // A byte completing on the same clk as cs rise is taken before the frame closes.
        if (cs_s2_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = (bit_cnt_d != 3'd0) || (state_q == ST_CMD);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q <= CPOL;
      sclk_s2_q <= CPOL;
      sclk_s3_q <= CPOL;
      cs_s1_q   <= 1'b0;
      cs_s2_q   <= 1'b0;
      in_s1_q   <= 1'b0;
      in_s2_q   <= 1'b0;
      state_q   <= ST_ARM;
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      tx_q      <= 8'h00;
      out_q     <= 1'b0;
      fresh_q   <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      rd_load_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= cs;
      cs_s2_q   <= cs_s1_q;
      in_s1_q   <= in;
      in_s2_q   <= in_s1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      out_q     <= out_d;
      fresh_q   <= fresh_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      rd_load_q <= rd_load_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign out        = out_q;
  assign out_en     = ((state_q == ST_CMD) || (state_q == ST_DATA)) && !cs_s2_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_addr    = rd_addr_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_follower_regs.sv
// Directed bench: one follower per CPOL/CPHA mode, driven by a behavioural SPI leader.
module tb_spi_follower_regs;
  localparam int ADDR_W = 7;
  localparam int W      = ADDR_W + 8;
  localparam int HALF   = 60;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sclk_drv, cs_drv, mosi;
  logic [1:0] cur;

  logic              sclk_a[4], cs_a[4];
  logic              out_a[4], out_en_a[4], wr_en_a[4], frame_done_a[4], frame_err_a[4];
  logic [ADDR_W-1:0] wr_addr_a[4], rd_addr_a[4];
  logic [7:0]        wr_data_a[4], rd_data_a[4];
  logic [1:0]        dbg_state_a[4];

  for (genvar m = 0; m < 4; m++) begin : g_dut
    localparam bit M_CPOL = (m / 2) == 1;
    localparam bit M_CPHA = (m % 2) == 1;
    assign sclk_a[m]    = (cur == 2'(m)) ? sclk_drv : M_CPOL;
    assign cs_a[m]      = (cur == 2'(m)) ? cs_drv : 1'b1;
    assign rd_data_a[m] = {rd_addr_a[m][6:0], 1'b0};
    spi_follower_regs #(.CPOL(M_CPOL), .CPHA(M_CPHA), .ADDR_W(ADDR_W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk_a[m]),
      .cs         (cs_a[m]),
      .in         (mosi),
      .out        (out_a[m]),
      .out_en     (out_en_a[m]),
      .wr_en      (wr_en_a[m]),
      .wr_addr    (wr_addr_a[m]),
      .wr_data    (wr_data_a[m]),
      .rd_addr    (rd_addr_a[m]),
      .rd_data    (rd_data_a[m]),
      .frame_done (frame_done_a[m]),
      .frame_err  (frame_err_a[m]),
      .dbg_state  (dbg_state_a[m])
    );
  end

  // scoreboard
  int checks;
  int errors;
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      obs_q[$];
  logic [ADDR_W-1:0] rdaddr_q[$];
  logic [ADDR_W-1:0] last_rd;
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_a[cur]) obs_q.push_back({wr_addr_a[cur], wr_data_a[cur]});
      if (frame_done_a[cur]) done_cnt <= done_cnt + 1;
      if (frame_done_a[cur] && frame_err_a[cur]) err_cnt <= err_cnt + 1;
      if (rd_addr_a[cur] != last_rd) rdaddr_q.push_back(rd_addr_a[cur]);
    end
    last_rd <= rd_addr_a[cur];
  end

  logic [7:0] tx_bytes[4];
  logic [7:0] rx_bytes[4];

  // driver tasks
  task automatic spi_bit(input logic b, output logic r);
    if (!cur[0]) begin
      mosi = b;
      #(HALF);
      sclk_drv = ~cur[1];
      r = out_a[cur];
      #(HALF);
      sclk_drv = cur[1];
    end else begin
      sclk_drv = ~cur[1];
      mosi = b;
      #(HALF);
      sclk_drv = cur[1];
      r = out_a[cur];
      #(HALF);
    end
  endtask

  task automatic spi_frame(input int nbytes, input int tail_bits, input bit use_cs);
    logic r;
    logic [7:0] byte_v;
    logic [7:0] rx_v;
    @(negedge clk);
    if (use_cs) cs_drv = 1'b0;
    #(HALF);
    for (int b = 0; b < nbytes; b++) begin
      byte_v = tx_bytes[b];
      for (int i = 7; i >= 0; i--) begin
        spi_bit(byte_v[i], r);
        rx_v[i] = r;
      end
      rx_bytes[b] = rx_v;
    end
    byte_v = tx_bytes[nbytes];
    for (int i = 0; i < tail_bits; i++) spi_bit(byte_v[7-i], r);
    #(HALF);
    if (use_cs) cs_drv = 1'b1;
    #(2*HALF);
  endtask

  task automatic select_mode(input logic [1:0] m);
    @(negedge clk);
    cs_drv   = 1'b1;
    cur      = m;
    sclk_drv = m[1];
    mosi     = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_writes(input string name);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_wr_count mode %0d: got %0d want %0d", name, cur, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_wr%0d mode %0d: got addr %h data %h want addr %h data %h", name, i, cur,
                   obs_q[i][W-1:8], obs_q[i][7:0], exp_q[i][W-1:8], exp_q[i][7:0]);
        end
      end
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    cs_drv = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (out_a[cur] !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", out_a[cur]); end
    checks++; if (out_en_a[cur] !== 1'b0) begin errors++; $display("FAIL reset_out_en: got %b want 0", out_en_a[cur]); end
    checks++; if (wr_en_a[cur] !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en_a[cur]); end
    checks++; if (wr_addr_a[cur] !== 7'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr_a[cur]); end
    checks++; if (wr_data_a[cur] !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data_a[cur]); end
    checks++; if (rd_addr_a[cur] !== 7'h00) begin errors++; $display("FAIL reset_rd_addr: got %h want 00", rd_addr_a[cur]); end
    checks++; if (frame_done_a[cur] !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done_a[cur]); end
    checks++; if (frame_err_a[cur] !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err_a[cur]); end
    checks++; if (dbg_state_a[cur] !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0 (ARM)", dbg_state_a[cur]); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (dbg_state_a[cur] !== 2'd1) begin errors++; $display("FAIL arm_to_idle: got %0d want 1 (IDLE)", dbg_state_a[cur]); end
  endtask

  task automatic test_single_write();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    obs_q.delete(); exp_q.delete();
    tx_bytes[0] = 8'h05; tx_bytes[1] = 8'hA7;
    spi_frame(2, 0, 1'b1);
    exp_q.push_back({7'h05, 8'hA7});
    check_writes("single");
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done mode %0d: got %0d want 1", cur, done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL single_err mode %0d: got %0d want 0", cur, err_cnt - e0); end
    checks++; if (out_en_a[cur] !== 1'b0) begin errors++; $display("FAIL single_out_en_idle mode %0d: got %b want 0", cur, out_en_a[cur]); end
  endtask

  task automatic test_burst_wrap();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    obs_q.delete(); exp_q.delete();
    tx_bytes[0] = 8'h7F; tx_bytes[1] = 8'h11; tx_bytes[2] = 8'h22;
    spi_frame(3, 0, 1'b1);
    exp_q.push_back({7'h7F, 8'h11});
    exp_q.push_back({7'h00, 8'h22});
    check_writes("burst");
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL burst_done: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL burst_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_read();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    obs_q.delete(); exp_q.delete(); rdaddr_q.delete();
    tx_bytes[0] = 8'h83; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00;
    spi_frame(3, 0, 1'b1);
    checks++; if (rx_bytes[0] !== 8'h00) begin errors++; $display("FAIL read_miso0 mode %0d: got %h want 00", cur, rx_bytes[0]); end
    checks++; if (rx_bytes[1] !== 8'h06) begin errors++; $display("FAIL read_miso1 mode %0d: got %h want 06", cur, rx_bytes[1]); end
    checks++; if (rx_bytes[2] !== 8'h08) begin errors++; $display("FAIL read_miso2 mode %0d: got %h want 08", cur, rx_bytes[2]); end
    checks++;
    if (rdaddr_q.size() < 2) begin
      errors++; $display("FAIL read_rd_addr_count mode %0d: got %0d want >=2", cur, rdaddr_q.size());
    end else if (rdaddr_q[0] !== 7'h03 || rdaddr_q[1] !== 7'h04) begin
      errors++; $display("FAIL read_rd_addr_seq mode %0d: got %h,%h want 03,04", cur, rdaddr_q[0], rdaddr_q[1]);
    end
    check_writes("read");
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL read_done mode %0d: got %0d want 1", cur, done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL read_err mode %0d: got %0d want 0", cur, err_cnt - e0); end
  endtask

  task automatic test_partial_byte();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    obs_q.delete(); exp_q.delete();
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'hFF;
    spi_frame(1, 5, 1'b1);
    check_writes("partial");
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL partial_done: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL partial_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_cs_only();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    cs_drv = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (out_en_a[cur] !== 1'b1) begin errors++; $display("FAIL cs_only_out_en_active: got %b want 1", out_en_a[cur]); end
    checks++; if (dbg_state_a[cur] !== 2'd2) begin errors++; $display("FAIL cs_only_state: got %0d want 2 (CMD)", dbg_state_a[cur]); end
    cs_drv = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (out_en_a[cur] !== 1'b0) begin errors++; $display("FAIL cs_only_out_en_idle: got %b want 0", out_en_a[cur]); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL cs_only_done: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL cs_only_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_cs_low_reset();
    int d0;
    d0 = done_cnt;
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    cs_drv = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h55;
    spi_frame(2, 0, 1'b0);
    check_writes("cs_low_rst_ignored");
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL cs_low_rst_done: got %0d want 0", done_cnt - d0); end
    checks++; if (dbg_state_a[cur] !== 2'd0) begin errors++; $display("FAIL cs_low_rst_state: got %0d want 0 (ARM)", dbg_state_a[cur]); end
    cs_drv = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (dbg_state_a[cur] !== 2'd1) begin errors++; $display("FAIL cs_high_state: got %0d want 1 (IDLE)", dbg_state_a[cur]); end
    spi_frame(2, 0, 1'b1);
    exp_q.push_back({7'h01, 8'h55});
    check_writes("after_cs_cycle");
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL after_cs_cycle_done: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cur = 2'd0;
    sclk_drv = 1'b0;
    cs_drv = 1'b1;
    mosi = 1'b0;
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_read();
    test_partial_byte();
    test_cs_only();
    for (int m = 1; m < 4; m++) begin
      select_mode(2'(m));
      test_single_write();
      test_read();
    end
    select_mode(2'd0);
    test_cs_low_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
